// File: rtl/mdu_seq_divider.sv
// Radix-2 restoring divider for RV64 div/divu/rem/remu, one op per valid/ready handshake.
// Optional macro MDU_DIV_FASTPATH_EN: special cases and small dividends bypass the iteration.
module mdu_seq_divider #(
  parameter int XLEN = 64
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            div,
  input  logic            divu,
  input  logic            rem,
  input  logic            remu,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] ZERO    = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONES    = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0]   CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]   CNT_TOP = CW'(XLEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic en);
    return en ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
  endfunction

  state_t          state_r;
  logic [XLEN-1:0] quo_r, rem_r, divisor_r, special_val_r, result_r;
  logic [CW-1:0]   count_r;
  logic            neg_q_r, neg_r_r, is_rem_r, special_r, in_ready_r, out_valid_r;

  logic            op_signed_s, op_is_rem_s, sign1_s, sign2_s;
  logic            div_zero_s, ovf_s, special_s;
  logic [XLEN-1:0] mag1_s, mag2_s, special_val_s;
`ifdef MDU_DIV_FASTPATH_EN
  logic [XLEN-1:0] small_val_s;
`endif
  logic [XLEN:0]   rem_sh_s, trial_s;
  logic [XLEN-1:0] quo_nxt_s, rem_nxt_s, final_s;

  // Request decode: magnitudes, signs and special-case results from the raw inputs.
  always_comb begin
    op_signed_s = div | rem;
    op_is_rem_s = rem | remu;
    sign1_s     = op_signed_s & src1[XLEN-1];
    sign2_s     = op_signed_s & src2[XLEN-1];
    mag1_s      = neg_if(src1, sign1_s);
    mag2_s      = neg_if(src2, sign2_s);
    div_zero_s  = (src2 == ZERO);
    ovf_s       = op_signed_s && (src1 == INT_MIN) && (src2 == ONES);
    special_s   = div_zero_s | ovf_s;
    if (div_zero_s) begin
      special_val_s = op_is_rem_s ? src1 : ONES;
    end else if (ovf_s) begin
      special_val_s = op_is_rem_s ? ZERO : src1;
    end else begin
      special_val_s = ZERO;
    end
`ifdef MDU_DIV_FASTPATH_EN
    small_val_s = op_is_rem_s ? src1 : ZERO;
`endif
  end

  // One restoring step plus the sign-fixed result of the step that would end CALC.
  always_comb begin
    rem_sh_s  = {rem_r, quo_r[XLEN-1]};
    trial_s   = rem_sh_s - {1'b0, divisor_r};
    quo_nxt_s = {quo_r[XLEN-2:0], ~trial_s[XLEN]};
    rem_nxt_s = trial_s[XLEN] ? rem_sh_s[XLEN-1:0] : trial_s[XLEN-1:0];
    if (special_r) begin
      final_s = special_val_r;
    end else if (is_rem_r) begin
      final_s = neg_if(rem_nxt_s, neg_r_r);
    end else begin
      final_s = neg_if(quo_nxt_s, neg_q_r);
    end
  end

  // Control FSM and datapath registers; flush overrides every other event.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= IDLE;
      quo_r         <= ZERO;
      rem_r         <= ZERO;
      divisor_r     <= ZERO;
      special_val_r <= ZERO;
      result_r      <= ZERO;
      count_r       <= {CW{1'b0}};
      neg_q_r       <= 1'b0;
      neg_r_r       <= 1'b0;
      is_rem_r      <= 1'b0;
      special_r     <= 1'b0;
      in_ready_r    <= 1'b1;
      out_valid_r   <= 1'b0;
    end else if (flush) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            quo_r         <= mag1_s;
            rem_r         <= ZERO;
            divisor_r     <= mag2_s;
            neg_q_r       <= sign1_s ^ sign2_s;
            neg_r_r       <= sign1_s;
            is_rem_r      <= op_is_rem_s;
            special_r     <= special_s;
            special_val_r <= special_val_s;
            count_r       <= CNT_TOP;
            in_ready_r    <= 1'b0;
`ifdef MDU_DIV_FASTPATH_EN
            if (special_s) begin
              state_r     <= DONE;
              out_valid_r <= 1'b1;
              result_r    <= special_val_s;
            end else if (mag1_s < mag2_s) begin
              state_r     <= DONE;
              out_valid_r <= 1'b1;
              result_r    <= small_val_s;
            end else begin
              state_r <= CALC;
            end
`else
            state_r <= CALC;
`endif
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          quo_r   <= quo_nxt_s;
          rem_r   <= rem_nxt_s;
          count_r <= count_r - CNT_ONE;
          if (count_r == {CW{1'b0}}) begin
            state_r     <= DONE;
            out_valid_r <= 1'b1;
            result_r    <= final_s;
          end else begin
            state_r <= CALC;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result    = result_r;

endmodule

// File: tb/tb_mdu_seq_divider.sv
// Scoreboard bench for mdu_seq_divider: driver queues expected results, monitor pops on each handshake.
module tb_mdu_seq_divider;

  localparam logic [63:0] ONES    = {64{1'b1}};
  localparam logic [63:0] INT_MIN = {1'b1, {63{1'b0}}};
  localparam logic [3:0]  F_DIV   = 4'b1000;
  localparam logic [3:0]  F_DIVU  = 4'b0100;
  localparam logic [3:0]  F_REM   = 4'b0010;
  localparam logic [3:0]  F_REMU  = 4'b0001;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        div = 1'b0, divu = 1'b0, rem = 1'b0, remu = 1'b0;
  logic [63:0] src1 = 64'd0, src2 = 64'd0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] result;

  int total = 0;
  int bad = 0;
  logic [63:0] exp_q[$];
  string       name_q[$];

  mdu_seq_divider #(.XLEN(64)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .div(div), .divu(divu), .rem(rem), .remu(remu), .src1(src1), .src2(src2),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", nm, act, exp);
    end
  endtask

  // Monitor: every accepted result is compared against the oldest queued expectation.
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready && !flush) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result got=%h expected=none", result);
      end else begin
        check(name_q.pop_front(), result, exp_q.pop_front());
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (!in_ready && k < 300) begin
      @(posedge clock);
      #1;
      k++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL idle_timeout got=busy expected=in_ready");
    end
  endtask

  task automatic issue(input logic [3:0] fl, input logic [63:0] a, input logic [63:0] b);
    wait_idle();
    @(negedge clock);
    {div, divu, rem, remu} = fl;
    src1 = a;
    src2 = b;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    {div, divu, rem, remu} = 4'b0000;
  endtask

  // Returns the number of rising edges, counted from the request cycle, until out_valid is seen.
  task automatic wait_valid(output int n);
    n = 1;
    while (!out_valid && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
  endtask

  task automatic do_op(input string nm, input logic [3:0] fl, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp, input bit fastable);
    int n;
    int exp_lat;
    exp_lat = 65;
`ifdef MDU_DIV_FASTPATH_EN
    if (fastable) exp_lat = 1;
`else
    if (fastable) exp_lat = 65;
`endif
    exp_q.push_back(exp);
    name_q.push_back(nm);
    issue(fl, a, b);
    wait_valid(n);
    check({nm, "_latency"}, 64'(n), 64'(exp_lat));
    wait_idle();
  endtask

  initial begin
    int n;
    int vcount;
    #12;
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_result", result, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;

    do_op("divu_100_7", F_DIVU, 64'd100, 64'd7, 64'd14, 1'b0);
    do_op("remu_100_7", F_REMU, 64'd100, 64'd7, 64'd2, 1'b0);
    do_op("div_m7_2", F_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    do_op("rem_m7_2", F_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 1'b0);
    do_op("rem_7_m2", F_REM, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 1'b0);
    do_op("div_m100_7", F_DIV, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 1'b0);
    do_op("rem_m100_7", F_REM, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    do_op("div_min_3", F_DIV, INT_MIN, 64'd3, 64'hD555_5555_5555_5556, 1'b0);
    do_op("rem_min_3", F_REM, INT_MIN, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    do_op("divu_ones_16", F_DIVU, ONES, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 1'b0);
    do_op("noflag_20_6", 4'b0000, 64'd20, 64'd6, 64'd3, 1'b0);
    do_op("div_5_0", F_DIV, 64'd5, 64'd0, ONES, 1'b1);
    do_op("divu_5_0", F_DIVU, 64'd5, 64'd0, ONES, 1'b1);
    do_op("rem_m5_0", F_REM, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1);
    do_op("div_ovf", F_DIV, INT_MIN, ONES, INT_MIN, 1'b1);
    do_op("rem_ovf", F_REM, INT_MIN, ONES, 64'd0, 1'b1);
    do_op("divu_3_10", F_DIVU, 64'd3, 64'd10, 64'd0, 1'b1);
    do_op("rem_m3_10", F_REM, 64'hFFFF_FFFF_FFFF_FFFD, 64'd10, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1);

    // Backpressure: result held for 10 cycles while a competing request is ignored.
    out_ready = 1'b0;
    exp_q.push_back(64'd10);
    name_q.push_back("bp_divu_50_5");
    issue(F_DIVU, 64'd50, 64'd5);
    wait_valid(n);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      {div, divu, rem, remu} = F_DIVU;
      src1 = 64'd77;
      src2 = 64'd7;
      in_valid = 1'b1;
      check("bp_result", result, 64'd10);
      check("bp_in_ready", {63'd0, in_ready}, 64'd0);
      check("bp_out_valid", {63'd0, out_valid}, 64'd1);
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    {div, divu, rem, remu} = 4'b0000;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    check("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
    check("bp_release_out_valid", {63'd0, out_valid}, 64'd0);
    check("bp_queue_drained", 64'(exp_q.size()), 64'd0);

    // Flush on CALC cycle 20 with a simultaneous request that must be ignored.
    issue(F_DIVU, 64'd1000, 64'd3);
    repeat (19) @(posedge clock);
    @(negedge clock);
    flush = 1'b1;
    {div, divu, rem, remu} = F_DIVU;
    src1 = 64'd5;
    src2 = 64'd1;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    {div, divu, rem, remu} = 4'b0000;
    check("flush_calc_in_ready", {63'd0, in_ready}, 64'd1);
    check("flush_calc_out_valid", {63'd0, out_valid}, 64'd0);
    vcount = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clock);
      #1;
      if (out_valid) vcount++;
    end
    check("flush_calc_no_valid", 64'(vcount), 64'd0);
    do_op("after_flush_9_3", F_DIVU, 64'd9, 64'd3, 64'd3, 1'b0);

    // Flush in DONE drops the result even with out_ready high.
    out_ready = 1'b0;
    issue(F_DIVU, 64'd8, 64'd2);
    wait_valid(n);
    flush = 1'b1;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    check("flush_done_out_valid", {63'd0, out_valid}, 64'd0);
    check("flush_done_in_ready", {63'd0, in_ready}, 64'd1);

    // Asynchronous reset in the middle of CALC.
    issue(F_DIVU, 64'd1000, 64'd3);
    repeat (5) @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    check("areset_in_ready", {63'd0, in_ready}, 64'd1);
    check("areset_out_valid", {63'd0, out_valid}, 64'd0);
    check("areset_result", result, 64'd0);
    @(posedge clock);
    #2;
    reset_n = 1'b1;
    do_op("after_reset_9_3", F_DIVU, 64'd9, 64'd3, 64'd3, 1'b0);

    repeat (3) @(posedge clock);
    check("queue_empty_at_end", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
